// File: rtl/gppm_seq_pkg.sv
// rtl/gppm_seq_pkg.sv - shared types and constants for the GPPM micro-program sequencer
package gppm_seq_pkg;

   localparam int PROG_W = 57;

   localparam logic [1:0] CTL_EXEC = 2'b00;
   localparam logic [1:0] CTL_BRZ  = 2'b01;
   localparam logic [1:0] CTL_JMP  = 2'b10;
   localparam logic [1:0] CTL_HALT = 2'b11;

   localparam int CTL_LSB    = 0;
   localparam int RA1_LSB    = 2;
   localparam int RA2_LSB    = 7;
   localparam int WA_LSB     = 12;
   localparam int ALU_OP_LSB = 17;
   localparam int WD_SEL_BIT = 21;
   localparam int WE_BIT     = 22;
   localparam int IMM_LSB    = 23;
   localparam int RSVD_LSB   = 55;

   // Field order matches the bit positions above, MSB first.
   typedef struct packed {
      logic [1:0]  rsvd;
      logic [31:0] imm;
      logic        we;
      logic        wd_sel;
      logic [3:0]  alu_op;
      logic [4:0]  wa;
      logic [4:0]  ra2;
      logic [4:0]  ra1;
      logic [1:0]  ctl;
   } prog_word_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DECODE
   } seq_state_t;

endpackage

// File: rtl/gppm_seq_pmem.sv
// rtl/gppm_seq_pmem.sv - program memory, one write port, synchronous read with read enable
module gppm_seq_pmem #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 57
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // rdata only moves on re, so a stalled decode keeps a stable word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/gppm_sequencer.sv
// rtl/gppm_sequencer.sv - GPPM micro-program sequencer; GPPM_SEQ_STEP_EN adds single-step input
module gppm_sequencer
   import gppm_seq_pkg::*;
#(
   parameter int PC_W      = 6,
   parameter int MAX_STEPS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PC_W-1:0]   start_pc,
   input  logic              abort,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [PROG_W-1:0] prog_wdata,
`ifdef GPPM_SEQ_STEP_EN
   input  logic              step,
`endif
   input  logic              is_zero,
   output logic [4:0]        ra1,
   output logic [4:0]        ra2,
   output logic [4:0]        wa,
   output logic [3:0]        alu_op,
   output logic              wd_sel,
   output logic              rf_we,
   output logic [31:0]       imm,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [PC_W-1:0]   pc
);

   seq_state_t        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       steps_q, steps_d;
   logic [4:0]        ra1_q, ra2_q, wa_q;
   logic [3:0]        alu_op_q;
   logic              wd_sel_q;
   logic [31:0]       imm_q;
   logic [PROG_W-1:0] rdata;
   prog_word_t        word;
   logic              mem_we, mem_re, go, wd_hit, unused_rsvd;
   logic [PC_W-1:0]   target;

   assign mem_we = prog_we && (state_q == IDLE);
   assign mem_re = (state_q == FETCH);

   gppm_seq_pmem #(
      .ADDR_W (PC_W),
      .DATA_W (PROG_W)
   ) u_pmem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .re    (mem_re),
      .raddr (pc_q),
      .rdata (rdata)
   );

   assign word        = rdata;
   assign target      = word.imm[PC_W-1:0];
   assign unused_rsvd = ^word.rsvd;
   assign wd_hit      = (MAX_STEPS != 0) && (steps_q == 32'(MAX_STEPS - 1));

`ifdef GPPM_SEQ_STEP_EN
   assign go = step;
`else
   assign go = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         steps_q  <= '0;
         ra1_q    <= '0;
         ra2_q    <= '0;
         wa_q     <= '0;
         alu_op_q <= '0;
         wd_sel_q <= 1'b0;
         imm_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         steps_q  <= steps_d;
         ra1_q    <= ra1;
         ra2_q    <= ra2;
         wa_q     <= wa;
         alu_op_q <= alu_op;
         wd_sel_q <= wd_sel;
         imm_q    <= imm;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      steps_d = steps_q;
      rf_we   = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      ra1     = ra1_q;
      ra2     = ra2_q;
      wa      = wa_q;
      alu_op  = alu_op_q;
      wd_sel  = wd_sel_q;
      imm     = imm_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               pc_d    = start_pc;
               steps_d = '0;
            end
         end
         FETCH: begin
            state_d = abort ? IDLE : DECODE;
         end
         DECODE: begin
            ra1    = word.ra1;
            ra2    = word.ra2;
            alu_op = word.alu_op;
            if (word.ctl == CTL_EXEC) begin
               wa     = word.wa;
               wd_sel = word.wd_sel;
               imm    = word.imm;
            end
            if (abort) begin
               state_d = IDLE;
            end else if (go) begin
               steps_d = steps_q + 32'd1;
               state_d = FETCH;
               // HALT retiring on the last permitted step still counts as a clean finish.
               if (word.ctl == CTL_HALT) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else if (wd_hit) begin
                  err     = 1'b1;
                  state_d = IDLE;
               end else begin
                  case (word.ctl)
                     CTL_EXEC: begin
                        rf_we = word.we;
                        pc_d  = pc_q + 1'b1;
                     end
                     CTL_BRZ: pc_d = is_zero ? target : pc_q + 1'b1;
                     default: pc_d = target;
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign pc   = pc_q;

endmodule

// File: tb/tb_gppm_sequencer.sv
// tb/tb_gppm_sequencer.sv - self-checking bench for gppm_sequencer (vector table, directed and random runs)
module tb_gppm_sequencer;
   import gppm_seq_pkg::*;

   localparam int PC_W      = 6;
   localparam int MAX_STEPS = 8;
   localparam int DEPTH     = 1 << PC_W;

   logic              clk = 1'b0;
   logic              rst, start, abort, prog_we, is_zero;
   logic [PC_W-1:0]   start_pc, prog_addr;
   logic [PROG_W-1:0] prog_wdata;
   logic [4:0]        ra1, ra2, wa;
   logic [3:0]        alu_op;
   logic              wd_sel, rf_we, busy, done, err;
   logic [31:0]       imm;
   logic [PC_W-1:0]   pc;
`ifdef GPPM_SEQ_STEP_EN
   logic              step = 1'b1;
`endif

   int         vec_cnt  = 0;
   int         miss_cnt = 0;
   prog_word_t mem_model [DEPTH];

   typedef struct {
      logic [1:0]      ctl;
      logic [PC_W-1:0] at;
      logic [31:0]     imm_v;
      logic            we_v;
      logic            z;
      logic            exp_we;
      logic            exp_done;
      logic [PC_W-1:0] exp_pc;
   } row_t;
   row_t rows [8];

   always #5 clk = ~clk;

   gppm_sequencer #(.PC_W(PC_W), .MAX_STEPS(MAX_STEPS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_pc   (start_pc),
      .abort      (abort),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
`ifdef GPPM_SEQ_STEP_EN
      .step       (step),
`endif
      .is_zero    (is_zero),
      .ra1        (ra1),
      .ra2        (ra2),
      .wa         (wa),
      .alu_op     (alu_op),
      .wd_sel     (wd_sel),
      .rf_we      (rf_we),
      .imm        (imm),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .pc         (pc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic prog_word_t mk(input logic [1:0] ctl, input logic [4:0] wa_v,
                                     input logic [31:0] imm_v, input logic we_v, input logic wd_v);
      prog_word_t w;
      w        = '0;
      w.ctl    = ctl;
      w.wa     = wa_v;
      w.imm    = imm_v;
      w.we     = we_v;
      w.wd_sel = wd_v;
      w.ra1    = 5'(wa_v + 5'd1);
      w.ra2    = 5'(wa_v + 5'd2);
      w.alu_op = imm_v[3:0];
      return w;
   endfunction

   function automatic prog_word_t rand_word();
      prog_word_t w;
      int         r;
      w = prog_word_t'({$urandom, $urandom});
      w.rsvd = 2'b00;
      r = $urandom_range(0, 9);
      w.ctl = (r < 5) ? CTL_EXEC : (r < 7) ? CTL_BRZ : (r < 9) ? CTL_JMP : CTL_HALT;
      return w;
   endfunction

   // Called at a falling edge while the sequencer is idle; returns at the next falling edge.
   task automatic load(input logic [PC_W-1:0] addr, input prog_word_t w);
      prog_addr       = addr;
      prog_wdata      = w;
      prog_we         = 1'b1;
      mem_model[addr] = w;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Returns at the falling edge inside the first FETCH cycle.
   task automatic start_run(input logic [PC_W-1:0] pc0);
      start    = 1'b1;
      start_pc = pc0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic abort_exit();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      prog_word_t      w;
      logic [PC_W-1:0] mpc, npc, pc0;
      logic [4:0]      h_ra1, h_ra2, h_wa;
      logic [3:0]      h_alu;
      logic            h_wd, e_we, e_done, e_err, z, finished;
      logic [31:0]     h_imm;
      int              steps, abort_at, k;

      rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0; is_zero = 1'b0;
      start_pc = '0; prog_addr = '0; prog_wdata = '0;

      rows[0] = '{CTL_EXEC, 6'd0,  32'd5,          1'b1, 1'b0, 1'b1, 1'b0, 6'd1};
      rows[1] = '{CTL_EXEC, 6'd63, 32'd9,          1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
      rows[2] = '{CTL_EXEC, 6'd7,  32'd3,          1'b0, 1'b1, 1'b0, 1'b0, 6'd8};
      rows[3] = '{CTL_BRZ,  6'd1,  32'd4,          1'b1, 1'b1, 1'b0, 1'b0, 6'd4};
      rows[4] = '{CTL_BRZ,  6'd1,  32'd4,          1'b1, 1'b0, 1'b0, 1'b0, 6'd2};
      rows[5] = '{CTL_JMP,  6'd10, 32'h1234_5667,  1'b1, 1'b0, 1'b0, 1'b0, 6'd39};
      rows[6] = '{CTL_HALT, 6'd5,  32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 6'd5};
      rows[7] = '{CTL_BRZ,  6'd63, 32'hFFFF_FF80,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0};

      @(negedge clk); @(negedge clk); #1;
      chk("rst_rf_we", rf_we, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_err", err, 0); chk("rst_pc", pc, 0); chk("rst_wa", wa, 0); chk("rst_imm", imm, 0);
      rst = 1'b0;
      @(negedge clk);
      for (int a = 0; a < DEPTH; a++) load(a[PC_W-1:0], mk(CTL_HALT, 5'd0, 32'd0, 1'b0, 1'b0));

      // EXEC then HALT: rf_we on the third cycle, done two cycles later, busy drops after done
      load(0, mk(CTL_EXEC, 5'd3, 32'd5, 1'b1, 1'b0));
      load(1, mk(CTL_HALT, 5'd0, 32'd0, 1'b0, 1'b0));
      start_run(0);
      #1 chk("basic_fetch_busy", busy, 1); chk("basic_fetch_we", rf_we, 0);
      @(negedge clk); #1;
      chk("basic_we", rf_we, 1); chk("basic_wa", wa, 3); chk("basic_imm", imm, 5); chk("basic_wdsel", wd_sel, 0);
      @(negedge clk); #1;
      chk("basic_we_pulse", rf_we, 0); chk("basic_pc1", pc, 1);
      @(negedge clk); #1;
      chk("basic_done", done, 1); chk("basic_busy_at_done", busy, 1);
      @(negedge clk); #1;
      chk("basic_done_end", done, 0); chk("basic_busy_end", busy, 0);

      for (int i = 0; i < 8; i++) begin
         w = mk(rows[i].ctl, 5'(i + 2), rows[i].imm_v, rows[i].we_v, 1'b1);
         load(rows[i].at, w);
         start_run(rows[i].at);
         #1 chk("row_busy", busy, 1);
         @(negedge clk);
         is_zero = rows[i].z;
         #1;
         chk("row_rf_we", rf_we, rows[i].exp_we); chk("row_done", done, rows[i].exp_done);
         chk("row_err", err, 0); chk("row_ra1", ra1, w.ra1); chk("row_alu_op", alu_op, w.alu_op);
         @(negedge clk);
         is_zero = 1'b0;
         #1;
         chk("row_pc", pc, rows[i].exp_pc); chk("row_busy_after", busy, !rows[i].exp_done);
         abort_exit();
         #1 chk("row_idle", busy, 0);
      end

      // abort in DECODE of a writing EXEC; a write during the run must be dropped
      load(12, mk(CTL_EXEC, 5'd9, 32'd44, 1'b1, 1'b0));
      start_run(12);
      prog_we = 1'b1; prog_addr = 12; prog_wdata = mk(CTL_HALT, 5'd1, 32'd1, 1'b0, 1'b0);
      @(negedge clk);
      prog_we = 1'b0; abort = 1'b1;
      #1 chk("abort_we", rf_we, 0); chk("abort_done", done, 0); chk("abort_err", err, 0);
      @(negedge clk);
      abort = 1'b0;
      #1 chk("abort_idle", busy, 0); chk("abort_done_after", done, 0); chk("abort_err_after", err, 0);
      start_run(12);
      @(negedge clk); #1;
      chk("busy_write_ignored_we", rf_we, 1); chk("busy_write_ignored_wa", wa, 9);
      abort_exit();

      // abort beats HALT; start beats abort in IDLE
      load(13, mk(CTL_HALT, 5'd0, 32'd0, 1'b0, 1'b0));
      start_run(13);
      @(negedge clk);
      abort = 1'b1;
      #1 chk("abort_halt_done", done, 0);
      @(negedge clk);
      #1 chk("abort_halt_idle", busy, 0);
      start = 1'b1; start_pc = 12;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1 chk("start_wins_busy", busy, 1);
      abort_exit();

      // watchdog on a self-loop at the top address
      load(63, mk(CTL_JMP, 5'd0, 32'd63, 1'b0, 1'b0));
      start_run(63);
      for (int s = 1; s <= MAX_STEPS; s++) begin
         @(negedge clk); #1;
         chk("wd_err", err, (s == MAX_STEPS)); chk("wd_done", done, 0); chk("wd_pc", pc, 63);
         if (s < MAX_STEPS) @(negedge clk);
      end
      @(negedge clk); #1;
      chk("wd_idle", busy, 0); chk("wd_err_pulse", err, 0);

      // asynchronous reset during a writing DECODE
      load(20, mk(CTL_EXEC, 5'd11, 32'd77, 1'b1, 1'b1));
      start_run(20);
      @(negedge clk); #1;
      chk("rstmid_pre_we", rf_we, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_we", rf_we, 0); chk("rstmid_busy", busy, 0); chk("rstmid_pc", pc, 0);
      chk("rstmid_wa", wa, 0); chk("rstmid_imm", imm, 0); chk("rstmid_ra1", ra1, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      start_run(20);
      @(negedge clk); #1;
      chk("rstmid_rerun_we", rf_we, 1); chk("rstmid_rerun_wa", wa, 11); chk("rstmid_rerun_pc", pc, 20);
      abort_exit();

`ifdef GPPM_SEQ_STEP_EN
      load(30, mk(CTL_EXEC, 5'd7, 32'd123, 1'b1, 1'b0));
      step = 1'b0;
      start_run(30);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk); #1;
         chk("step_hold_we", rf_we, 0); chk("step_hold_wa", wa, 7); chk("step_hold_pc", pc, 30);
      end
      @(negedge clk);
      step = 1'b1;
      #1 chk("step_go_we", rf_we, 1);
      @(negedge clk); #1;
      chk("step_pc", pc, 31); chk("step_we_single", rf_we, 0);
      abort_exit();
`endif

      // randomized runs against an instruction-level model
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      h_ra1 = '0; h_ra2 = '0; h_wa = '0; h_alu = '0; h_wd = 1'b0; h_imm = '0;
      for (int run = 0; run < 40; run++) begin
         for (int j = 0; j < 6; j++) load(PC_W'($urandom), rand_word());
         pc0      = PC_W'($urandom);
         abort_at = $urandom_range(0, 11);
         start_run(pc0);
         mpc = pc0; steps = 0; finished = 1'b0; k = 0;
         while (!finished) begin
            prog_we = 1'($urandom); prog_addr = PC_W'($urandom); prog_wdata = rand_word();
            #1;
            chk("rnd_fetch_busy", busy, 1); chk("rnd_fetch_we", rf_we, 0); chk("rnd_fetch_pc", pc, mpc);
            chk("rnd_hold_ra1", ra1, h_ra1); chk("rnd_hold_wa", wa, h_wa); chk("rnd_hold_imm", imm, h_imm);
            @(negedge clk);
            w       = mem_model[mpc];
            z       = 1'($urandom);
            is_zero = z;
            abort   = (k == abort_at);
            prog_we = 1'($urandom); prog_addr = PC_W'($urandom); prog_wdata = rand_word();
            #1;
            steps++;
            h_ra1 = w.ra1; h_ra2 = w.ra2; h_alu = w.alu_op;
            if (w.ctl == CTL_EXEC) begin
               h_wa = w.wa; h_wd = w.wd_sel; h_imm = w.imm;
            end
            e_we = 1'b0; e_done = 1'b0; e_err = 1'b0; npc = mpc;
            if (abort) finished = 1'b1;
            else if (w.ctl == CTL_HALT) begin
               e_done = 1'b1; finished = 1'b1;
            end else if (steps == MAX_STEPS) begin
               e_err = 1'b1; finished = 1'b1;
            end else if (w.ctl == CTL_EXEC) begin
               e_we = w.we; npc = mpc + 1'b1;
            end else if (w.ctl == CTL_BRZ) npc = z ? w.imm[PC_W-1:0] : mpc + 1'b1;
            else npc = w.imm[PC_W-1:0];
            chk("rnd_rf_we", rf_we, e_we); chk("rnd_done", done, e_done); chk("rnd_err", err, e_err);
            chk("rnd_pc", pc, mpc); chk("rnd_busy", busy, 1);
            chk("rnd_ra1", ra1, h_ra1); chk("rnd_ra2", ra2, h_ra2); chk("rnd_alu_op", alu_op, h_alu);
            chk("rnd_wa", wa, h_wa); chk("rnd_wd_sel", wd_sel, h_wd); chk("rnd_imm", imm, h_imm);
            mpc = npc;
            k++;
            @(negedge clk);
            abort = 1'b0; prog_we = 1'b0;
         end
         #1;
         chk("rnd_end_busy", busy, 0); chk("rnd_end_we", rf_we, 0); chk("rnd_end_done", done, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
